parallel_fetch_unit: RTL and testbench

PARALLEL_FETCH_UNIT -- requirements
Module: parallel_fetch_unit

---
 rtl/pfu_pkg.sv | 17 +
 rtl/pfu_port_ctrl.sv | 122 ++++++++++++
 rtl/parallel_fetch_unit.sv | 56 +++++
 tb/tb_parallel_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pfu_pkg.sv
// Shared types and defaults for the parallel fetch unit.
// State enum, halt word and default widths.
package pfu_pkg;

  localparam int PFU_NUM_PORTS = 4;
  localparam int PFU_ADDR_W    = 16;
  localparam int PFU_DATA_W    = 16;

  localparam logic [PFU_DATA_W-1:0] HALT_WORD = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } pfu_state_e;

endpackage

// File: rtl/pfu_port_ctrl.sv
// One independent fetch port: IDLE/FETCH/HALTED with decode handshake.
// Optional stall counter under PFU_STALL_CNT_EN.
import pfu_pkg::*;

module pfu_port_ctrl #(
  parameter int ADDR_W = PFU_ADDR_W,
  parameter int DATA_W = PFU_DATA_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
`ifdef PFU_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              halted
);

  pfu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              take;
  logic              is_halt;

  // All-ones word, evaluated at the port's own data width
  assign is_halt = &mem_dataout;
  assign take    = !valid_q || instr_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = start_pc;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (take) begin
          if (is_halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
            valid_d  = 1'b0;
          end else begin
            instr_d = mem_dataout;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
          end
        end
      end
      HALTED: begin
        if (valid_q && instr_ready) valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

`ifdef PFU_STALL_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && start) begin
      cnt_d = '0;
    end else if (state_q == FETCH && valid_q && !instr_ready) begin
      if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`endif

  assign mem_address = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: rtl/parallel_fetch_unit.sv
// NUM_PORTS independent fetch ports sharing clock, reset and start.
// Define PFU_STALL_CNT_EN to add per-port stall counters.
import pfu_pkg::*;

module parallel_fetch_unit #(
  parameter int NUM_PORTS = PFU_NUM_PORTS,
  parameter int ADDR_W    = PFU_ADDR_W,
  parameter int DATA_W    = PFU_DATA_W
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_pc       [0:NUM_PORTS-1],
  output logic [ADDR_W-1:0]    mem_address    [0:NUM_PORTS-1],
  input  logic [DATA_W-1:0]    mem_dataout    [0:NUM_PORTS-1],
  input  logic [NUM_PORTS-1:0] redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc    [0:NUM_PORTS-1],
  output logic [DATA_W-1:0]    instr          [0:NUM_PORTS-1],
  output logic [ADDR_W-1:0]    instr_pc       [0:NUM_PORTS-1],
  output logic [NUM_PORTS-1:0] instr_valid,
  input  logic [NUM_PORTS-1:0] instr_ready,
`ifdef PFU_STALL_CNT_EN
  output logic [15:0]          stall_cnt      [0:NUM_PORTS-1],
`endif
  output logic [NUM_PORTS-1:0] halted,
  output logic                 all_halted
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    pfu_port_ctrl #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_ctrl (
      .clk           (clk),
      .clear_n       (clear_n),
      .start         (start),
      .start_pc      (start_pc[i]),
      .mem_address   (mem_address[i]),
      .mem_dataout   (mem_dataout[i]),
      .redirect_valid(redirect_valid[i]),
      .redirect_pc   (redirect_pc[i]),
      .instr_ready   (instr_ready[i]),
      .instr         (instr[i]),
      .instr_pc      (instr_pc[i]),
      .instr_valid   (instr_valid[i]),
`ifdef PFU_STALL_CNT_EN
      .stall_cnt     (stall_cnt[i]),
`endif
      .halted        (halted[i])
    );
  end

  // A port can only be halted after leaving IDLE
  assign all_halted = &halted;

endmodule

// File: tb/tb_parallel_fetch_unit.sv
// Directed bench for parallel_fetch_unit with a combinational RAM model.
// Covers capture, stall, halt, redirect, pc wrap and async reset.
`timescale 1ns/1ps
import pfu_pkg::*;

module tb_parallel_fetch_unit;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          clear_n;
  logic          start;
  logic [15:0]   start_pc    [0:NP-1];
  logic [15:0]   mem_address [0:NP-1];
  logic [15:0]   mem_dataout [0:NP-1];
  logic [NP-1:0] redirect_valid;
  logic [15:0]   redirect_pc [0:NP-1];
  logic [15:0]   instr       [0:NP-1];
  logic [15:0]   instr_pc    [0:NP-1];
  logic [NP-1:0] instr_valid;
  logic [NP-1:0] instr_ready;
  logic [NP-1:0] halted;
  logic          all_halted;
`ifdef PFU_STALL_CNT_EN
  logic [15:0]   stall_cnt   [0:NP-1];
`endif

  logic [15:0] mem [0:65535];

  int n_chk = 0;
  int n_err = 0;

  parallel_fetch_unit #(
    .NUM_PORTS(NP),
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .clk           (clk),
    .clear_n       (clear_n),
    .start         (start),
    .start_pc      (start_pc),
    .mem_address   (mem_address),
    .mem_dataout   (mem_dataout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
`ifdef PFU_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .halted        (halted),
    .all_halted    (all_halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) mem_dataout[i] = mem[mem_address[i]];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_init();
    for (int a = 0; a < 65536; a++) begin
      if (a < 2) mem[a] = 16'(a);
      else       mem[a] = 16'h8000 | 16'(a);
    end
  endtask

  task automatic do_reset();
    clear_n        = 1'b0;
    start          = 1'b0;
    instr_ready    = '1;
    redirect_valid = '0;
    for (int i = 0; i < NP; i++) begin
      start_pc[i]    = 16'(3 * i);
      redirect_pc[i] = '0;
    end
    tick();
    tick();
    clear_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    mem_init();

    // Reset state and start-less release
    do_reset();
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_all_halted", 32'(all_halted), 32'h0);
    chk("rst_instr0", 32'(instr[0]), 32'h0);
    redirect_valid[1] = 1'b1;
    redirect_pc[1]    = 16'h0055;
    tick();
    tick();
    redirect_valid = '0;
    chk("idle_no_fetch", 32'(instr_valid), 32'h0);
    chk("idle_redir_ign", 32'(mem_address[1]), 32'h0);

    // Sequential capture on port 0
    do_start();
    chk("start_addr0", 32'(mem_address[0]), 32'h0);
    chk("start_addr3", 32'(mem_address[3]), 32'h9);
    tick();
    chk("p0_w0", 32'(instr[0]), 32'h0000);
    chk("p0_v0", 32'(instr_valid[0]), 32'h1);
    tick();
    chk("p0_w1", 32'(instr[0]), 32'h0001);
    chk("p0_pc1", 32'(instr_pc[0]), 32'h1);
    tick();
    chk("p0_w2", 32'(instr[0]), 32'h8002);
    chk("p3_w2", 32'(instr[3]), 32'h800B);

    // Stall on port 1
    do_reset();
    instr_ready[1] = 1'b0;
    do_start();
    tick();
    chk("p1_cap", 32'(instr[1]), 32'h8003);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("p1_hold_instr", 32'(instr[1]), 32'h8003);
      chk("p1_hold_ipc", 32'(instr_pc[1]), 32'h3);
      chk("p1_hold_pc", 32'(mem_address[1]), 32'h4);
    end
    chk("p2_indep", 32'(instr[2]), 32'h8009);
`ifdef PFU_STALL_CNT_EN
    chk("p1_stall_cnt", 32'(stall_cnt[1]), 32'h3);
    chk("p0_stall_cnt", 32'(stall_cnt[0]), 32'h0);
`endif
    instr_ready[1] = 1'b1;
    tick();
    chk("p1_resume", 32'(instr[1]), 32'h8004);

    // Halt word on port 0
    mem[5] = HALT_WORD;
    do_reset();
    start_pc[0] = 16'h0004;
    do_start();
    tick();
    chk("h_w0", 32'(instr[0]), 32'h8004);
    tick();
    chk("h_halted", 32'(halted[0]), 32'h1);
    chk("h_valid", 32'(instr_valid[0]), 32'h0);
    chk("h_addr", 32'(mem_address[0]), 32'h5);
    chk("h_all_partial", 32'(all_halted), 32'h0);
    redirect_valid[0] = 1'b1;
    tick();
    redirect_valid[0] = 1'b0;
    tick();
    chk("h_addr_hold", 32'(mem_address[0]), 32'h5);
    chk("h_still_invalid", 32'(instr_valid[0]), 32'h0);
    mem[5] = 16'h8005;

    // Every port halts
    do_reset();
    for (int i = 0; i < NP; i++) mem[3 * i] = HALT_WORD;
    do_start();
    tick();
    chk("all_halted", 32'(all_halted), 32'h1);
    chk("all_halted_vec", 32'(halted), 32'hF);
    mem_init();

    // Redirect on port 2
    do_reset();
    do_start();
    tick();
    chk("r_w0", 32'(instr[2]), 32'h8006);
    redirect_valid[2] = 1'b1;
    redirect_pc[2]    = 16'h0000;
    tick();
    redirect_valid[2] = 1'b0;
    chk("r_valid_clr", 32'(instr_valid[2]), 32'h0);
    chk("r_addr", 32'(mem_address[2]), 32'h0);
    chk("r_p0_indep", 32'(instr[0]), 32'h0001);
    tick();
    chk("r_instr", 32'(instr[2]), 32'h0000);
    chk("r_ipc", 32'(instr_pc[2]), 32'h0);
    chk("r_valid", 32'(instr_valid[2]), 32'h1);

    // pc wrap on port 3, then async reset mid-fetch
    mem[16'hFFFF] = 16'hFFFE;
    do_reset();
    start_pc[3] = 16'hFFFF;
    do_start();
    tick();
    chk("w_instr", 32'(instr[3]), 32'hFFFE);
    chk("w_ipc", 32'(instr_pc[3]), 32'hFFFF);
    chk("w_addr", 32'(mem_address[3]), 32'h0);
    tick();
    chk("w_instr2", 32'(instr[3]), 32'h0000);
    #2;
    clear_n = 1'b0;
    #1;
    chk("ar_valid", 32'(instr_valid), 32'h0);
    chk("ar_instr3", 32'(instr[3]), 32'h0);
    chk("ar_ipc3", 32'(instr_pc[3]), 32'h0);
    chk("ar_addr3", 32'(mem_address[3]), 32'h0);
    chk("ar_addr0", 32'(mem_address[0]), 32'h0);
    tick();
    clear_n = 1'b1;
    tick();
    tick();
    chk("ar_no_restart", 32'(instr_valid), 32'h0);
    do_start();
    tick();
    chk("ar_restart", 32'(instr[3]), 32'hFFFE);
    chk("ar_restart_v", 32'(instr_valid), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
